// File: rtl/dxball_pkg.sv
// Shared definitions for the DX-Ball playfield blocks (ball motion controller,
// brick collision logic and the VGA drawer).
// Contents:
//   ball_state_t : ball motion controller FSM states
//   SCREEN_W/H   : playfield size in pixels
//   BALL_RADIUS  : ball half-size; the ball is a BALL_SIZE square
//   PADDLE_Y/W   : paddle top row and width
//   SPEEDUP_HITS : brick hits per speed step (BALL_SPEEDUP_EN builds only)
package dxball_pkg;

  localparam int SCREEN_W     = 160;
  localparam int SCREEN_H     = 120;
  localparam int BALL_RADIUS  = 2;
  localparam int BALL_SIZE    = 2 * BALL_RADIUS;
  localparam int PADDLE_Y     = 112;
  localparam int PADDLE_W     = 24;
  localparam int SPEEDUP_HITS = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ERASE,
    S_UPDATE,
    S_DRAW
  } ball_state_t;

endpackage

// File: rtl/ball_axis_step.sv
// One axis of ball motion: steps a position by +/-step, reflecting at the
// low wall (position 0) and handling the far edge either as a reflecting
// wall (clamp to FAR_LIMIT) or as a losing edge (lost=1).  The optional
// paddle window reflects a forward-moving ball that would cross PADDLE_POS.
// Arithmetic is done one bit wider than the position so pos+step never wraps.
// Ports:
//   pos           current position (top-left coordinate on this axis)
//   dir           1 = moving towards the far edge
//   step          pixels per frame
//   paddle_window 1 = ball overlaps the paddle on the other axis
//   next_pos      stepped/clamped position
//   next_dir      direction after any reflection
//   lost          far edge reached on a losing axis
module ball_axis_step #(
  parameter int PW         = 8,
  parameter int FAR_LIMIT  = 156,
  parameter bit FAR_LOST   = 1'b0,
  parameter bit HAS_PADDLE = 1'b0,
  parameter int PADDLE_POS = 108
) (
  input  logic [PW-1:0] pos,
  input  logic          dir,
  input  logic [1:0]    step,
  input  logic          paddle_window,
  output logic [PW-1:0] next_pos,
  output logic          next_dir,
  output logic          lost
);

  localparam int        PW1   = PW + 1;
  localparam logic [PW:0] FAR_L = PW1'(FAR_LIMIT);
  localparam logic [PW:0] PAD_L = PW1'(PADDLE_POS);

  logic [PW:0] pos_w;
  logic [PW:0] step_w;
  logic [PW:0] fwd;

  assign pos_w  = {1'b0, pos};
  assign step_w = PW1'(step);
  assign fwd    = pos_w + step_w;

  always_comb begin
    next_pos = pos;
    next_dir = dir;
    lost     = 1'b0;
    if (dir) begin
      // Paddle is checked before the far edge: a ball resting on the paddle
      // line must bounce even if a full step would carry it past the floor.
      if (HAS_PADDLE && paddle_window && (pos_w <= PAD_L) && (fwd >= PAD_L)) begin
        next_pos = PAD_L[PW-1:0];
        next_dir = 1'b0;
      end else if (fwd >= FAR_L) begin
        if (FAR_LOST) begin
          lost = 1'b1;
        end else begin
          next_pos = FAR_L[PW-1:0];
          next_dir = 1'b0;
        end
      end else begin
        next_pos = fwd[PW-1:0];
      end
    end else begin
      if (pos_w < step_w) begin
        next_pos = '0;
        next_dir = 1'b1;
      end else begin
        next_pos = pos - step_w[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Per-frame ball position/direction controller.  Takes the brick collision
// verdict, applies wall/paddle/floor rules, steps the ball once per frame
// tick and sequences erase/redraw requests to the VGA drawer.
// Optional feature macro: BALL_SPEEDUP_EN (brick hits raise the step size).
// Ports:
//   clock, resetn      clock, synchronous active-low reset
//   frame_tick         one-cycle pulse per frame
//   launch             serve request (level)
//   paddle_x           paddle left x
//   brick_collision    brick verdict valid; brick_down/brick_right give the
//                      new direction
//   draw_ack           drawer finished the current request
//   posX, posY         ball top-left position
//   DOWN, RIGHT        ball direction (1 = down / right)
//   draw_req           drawer request, draw_erase selects erase (1) or draw (0)
//   ball_lost          one-cycle pulse when the ball hits the floor
//   in_play            high outside S_IDLE
//   dbg_state          current FSM state
module ball_motion_ctrl
  import dxball_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        launch,
  input  logic [7:0]  paddle_x,
  input  logic        brick_collision,
  input  logic        brick_down,
  input  logic        brick_right,
  input  logic        draw_ack,
  output logic [7:0]  posX,
  output logic [6:0]  posY,
  output logic        DOWN,
  output logic        RIGHT,
  output logic        draw_req,
  output logic        draw_erase,
  output logic        ball_lost,
  output logic        in_play,
  output ball_state_t dbg_state
);

  localparam logic [7:0] RESET_X     = 8'(SCREEN_W / 2 - BALL_RADIUS);
  localparam logic [7:0] SERVE_X_OFS = 8'(PADDLE_W / 2 - BALL_RADIUS);
  localparam logic [6:0] REST_Y      = 7'(PADDLE_Y - BALL_SIZE);

  ball_state_t state;
  logic [1:0]  step;
  logic        dir_x, dir_y;
  logic        paddle_window;
  logic [7:0]  nx;
  logic [6:0]  ny;
  logic        ndx, ndy;
  logic        x_lost, y_lost, lost;

  assign dbg_state = state;

  // A brick verdict replaces the direction before stepping; wall and paddle
  // rules inside the axis units then override it on their own axis.
  assign dir_x = brick_collision ? brick_right : RIGHT;
  assign dir_y = brick_collision ? brick_down  : DOWN;

  // Ball span [posX, posX+BALL_SIZE-1] overlaps paddle span, 9-bit compare.
  assign paddle_window = (({1'b0, posX} + 9'(BALL_SIZE - 1)) >= {1'b0, paddle_x}) &&
                         ({1'b0, posX} <= ({1'b0, paddle_x} + 9'(PADDLE_W - 1)));

  ball_axis_step #(
    .PW         (8),
    .FAR_LIMIT  (SCREEN_W - BALL_SIZE),
    .FAR_LOST   (1'b0),
    .HAS_PADDLE (1'b0),
    .PADDLE_POS (0)
  ) u_step_x (
    .pos           (posX),
    .dir           (dir_x),
    .step          (step),
    .paddle_window (1'b0),
    .next_pos      (nx),
    .next_dir      (ndx),
    .lost          (x_lost)
  );

  // Floor condition posY+step+BALL_SIZE > SCREEN_H is pos+step >= FAR_LIMIT.
  ball_axis_step #(
    .PW         (7),
    .FAR_LIMIT  (SCREEN_H - BALL_SIZE + 1),
    .FAR_LOST   (1'b1),
    .HAS_PADDLE (1'b1),
    .PADDLE_POS (PADDLE_Y - BALL_SIZE)
  ) u_step_y (
    .pos           (posY),
    .dir           (dir_y),
    .step          (step),
    .paddle_window (paddle_window),
    .next_pos      (ny),
    .next_dir      (ndy),
    .lost          (y_lost)
  );

  assign lost = x_lost | y_lost;

  // Drawer handshake: draw_req rises with draw_erase/posX/posY valid and all
  // of them hold steady until the cycle draw_ack is sampled high while
  // draw_req is high; that cycle completes the transfer and draw_req drops
  // on the next edge.  draw_ack while draw_req is low means nothing.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state      <= S_IDLE;
      posX       <= RESET_X;
      posY       <= REST_Y;
      DOWN       <= 1'b0;
      RIGHT      <= 1'b1;
      draw_req   <= 1'b0;
      draw_erase <= 1'b0;
      ball_lost  <= 1'b0;
      in_play    <= 1'b0;
    end else begin
      ball_lost <= 1'b0;
      case (state)
        S_IDLE: begin
          // Ball rides on the paddle until served.
          posX  <= paddle_x + SERVE_X_OFS;
          posY  <= REST_Y;
          DOWN  <= 1'b0;
          RIGHT <= 1'b1;
          if (launch) begin
            state   <= S_WAIT;
            in_play <= 1'b1;
          end
        end
        S_WAIT: begin
          if (frame_tick) begin
            state      <= S_ERASE;
            draw_req   <= 1'b1;
            draw_erase <= 1'b1;
          end
        end
        S_ERASE: begin
          if (draw_ack) begin
            state    <= S_UPDATE;
            draw_req <= 1'b0;
          end
        end
        S_UPDATE: begin
          if (lost) begin
            state     <= S_IDLE;
            ball_lost <= 1'b1;
            in_play   <= 1'b0;
          end else begin
            posX       <= nx;
            posY       <= ny;
            RIGHT      <= ndx;
            DOWN       <= ndy;
            state      <= S_DRAW;
            draw_req   <= 1'b1;
            draw_erase <= 1'b0;
          end
        end
        S_DRAW: begin
          if (draw_ack) begin
            state    <= S_WAIT;
            draw_req <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          draw_req <= 1'b0;
          in_play  <= 1'b0;
        end
      endcase
    end
  end

`ifdef BALL_SPEEDUP_EN
  logic [3:0] hit_cnt;

  // Step used in an update is the one registered before it; a speed-up
  // takes effect from the following frame.  Losing the ball serves again
  // at base speed.
  always_ff @(posedge clock) begin
    if (!resetn || (state == S_UPDATE && lost)) begin
      step    <= 2'd1;
      hit_cnt <= 4'd0;
    end else if (state == S_UPDATE && brick_collision) begin
      if (hit_cnt == 4'(SPEEDUP_HITS - 1)) begin
        hit_cnt <= 4'd0;
        if (step != 2'd3) step <= step + 2'd1;
      end else begin
        hit_cnt <= hit_cnt + 4'd1;
      end
    end
  end
`else
  assign step = 2'd1;
`endif

endmodule
